// File: rtl/uart_rx_con.sv
// 8N1 UART receiver: 2-flop input synchronizer, mid-bit sampling FSM and a
// single-byte holding register with read-to-clear status flags.
module uart_rx_con #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rd,
  output logic [7:0] data_out,
  output logic       rx_full,
  output logic       rx_done,
  output logic       frame_err,
  output logic       overrun
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  idx, idx_n;
  logic [7:0]  shift;
  logic        rx_meta, rx_sync;
  logic        brk, brk_n;
  logic        sample_bit, frame_ok, frame_bad;

  // Synchronizer resets to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      brk   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      brk   <= brk_n;
    end
  end

  // NOTE: every variable gets a default before the case so no path infers a latch.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt + 16'd1;
    idx_n      = idx;
    brk_n      = brk;
    sample_bit = 1'b0;
    frame_ok   = 1'b0;
    frame_bad  = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        // After a low stop bit (break) wait for the line to go high before re-arming.
        if (rx_sync)   brk_n   = 1'b0;
        else if (!brk) state_n = START;
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = rx_sync ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n      = '0;
          sample_bit = 1'b1;
          idx_n      = idx + 3'd1;
          if (idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          state_n = IDLE;
          if (rx_sync) begin
            frame_ok = 1'b1;
          end else begin
            frame_bad = 1'b1;
            brk_n     = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Holding register and status flags; a flag being set wins over rd clearing it.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift     <= '0;
      data_out  <= '0;
      rx_full   <= 1'b0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (sample_bit) shift[idx] <= rx_sync;
      rx_done <= frame_ok;
      if (frame_ok) data_out <= shift;

      if (frame_ok)  rx_full <= 1'b1;
      else if (rd)   rx_full <= 1'b0;

      if (frame_ok && rx_full && !rd) overrun <= 1'b1;
      else if (rd)                    overrun <= 1'b0;

      if (frame_bad) frame_err <= 1'b1;
      else if (rd)   frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_con.sv
// Self-checking bench for uart_rx_con: frame-level reference model checked every
// cycle, directed scenarios with literal expectations, then randomized frames.
module tb_uart_rx_con;

  localparam int C   = 16;
  localparam int LAT = 2 + C / 2 + 9 * C + 1;

  logic       clk;
  logic       reset;
  logic       rx;
  logic       rd;
  logic [7:0] data_out;
  logic       rx_full;
  logic       rx_done;
  logic       frame_err;
  logic       overrun;

  uart_rx_con #(.CLKS_PER_BIT(C)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rd        (rd),
    .data_out  (data_out),
    .rx_full   (rx_full),
    .rx_done   (rx_done),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected frame completions, each at the edge where the receiver must finish it.
  typedef struct {
    int         t;
    bit         ok;
    logic [7:0] b;
  } ev_t;

  ev_t        q[$];
  int         cyc     = 0;
  int         vectors = 0;
  int         errors  = 0;
  int         pulses  = 0;
  logic [7:0] data_m  = '0;
  logic       full_m  = 1'b0;
  logic       ferr_m  = 1'b0;
  logic       ovr_m   = 1'b0;
  logic       done_m  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_outs(input string name, input logic [7:0] d, input logic f,
                            input logic fe, input logic ov);
    check({name, ".data_out"},  32'(data_out),  32'(d));
    check({name, ".rx_full"},   32'(rx_full),   32'(f));
    check({name, ".frame_err"}, 32'(frame_err), 32'(fe));
    check({name, ".overrun"},   32'(overrun),   32'(ov));
  endtask

  // Reference model: apply spec rules at each edge, compare on the following negedge.
  initial begin
    logic rd_s, rst_s, ok_now, bad_now;
    logic [7:0] b_now;
    ev_t e;
    forever begin
      @(posedge clk);
      cyc++;
      rd_s    = rd;
      rst_s   = reset;
      done_m  = 1'b0;
      ok_now  = 1'b0;
      bad_now = 1'b0;
      b_now   = '0;
      if (rst_s) begin
        data_m = '0; full_m = 1'b0; ferr_m = 1'b0; ovr_m = 1'b0;
        q.delete();
      end else begin
        while (q.size() > 0 && q[0].t < cyc) void'(q.pop_front());
        if (q.size() > 0 && q[0].t == cyc) begin
          e       = q.pop_front();
          ok_now  = e.ok;
          bad_now = !e.ok;
          b_now   = e.b;
        end
        if (ok_now) begin
          if (full_m && !rd_s) ovr_m = 1'b1;
          else if (rd_s)       ovr_m = 1'b0;
          full_m = 1'b1;
          data_m = b_now;
          done_m = 1'b1;
        end else if (rd_s) begin
          full_m = 1'b0;
          ovr_m  = 1'b0;
        end
        if (bad_now)   ferr_m = 1'b1;
        else if (rd_s) ferr_m = 1'b0;
      end
      @(negedge clk);
      check("rx_done",   32'(rx_done),   32'(done_m));
      check("data_out",  32'(data_out),  32'(data_m));
      check("rx_full",   32'(rx_full),   32'(full_m));
      check("frame_err", 32'(frame_err), 32'(ferr_m));
      check("overrun",   32'(overrun),   32'(ovr_m));
      if (rx_done === 1'b1) pulses++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  // All driver tasks start at a negedge slot and return at a fresh negedge slot.
  task automatic idle(input int n, input bit rand_rd);
    for (int i = 0; i < n; i++) begin
      rx = 1'b1;
      rd = rand_rd && full_m && ($urandom_range(0, 15) == 0);
      @(negedge clk);
    end
    rd = 1'b0;
  endtask

  task automatic pulse_rd();
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int rd_at);
    logic [9:0] bits;
    ev_t e;
    int k;
    bits = {stop, b, 1'b0};
    e.t  = cyc + LAT;
    e.ok = stop;
    e.b  = b;
    q.push_back(e);
    for (int i = 0; i < 10 * C; i++) begin
      if (i > 0) @(negedge clk);
      k  = i / C;
      rx = bits[k[3:0]];
      rd = (i == rd_at) && full_m;
    end
    @(negedge clk);
    rd = 1'b0;
  endtask

  initial begin
    int p0, gap, rd_at;
    bit prev_bad;
    logic [7:0] b;
    logic stop;
    logic [9:0] bits;
    ev_t e;
    int k;

    rx = 1'b1; rd = 1'b0; reset = 1'b1;
    repeat (3) @(negedge clk);
    check_outs("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    check("reset.rx_done", 32'(rx_done), 32'(0));
    reset = 1'b0;
    idle(2 * C, 1'b0);

    // Single valid frame.
    p0 = pulses;
    send_frame(8'h55, 1'b1, -1);
    idle(2 * C, 1'b0);
    check_outs("f55", 8'h55, 1'b1, 1'b0, 1'b0);
    check("f55.pulses", 32'(pulses - p0), 32'(1));
    pulse_rd();
    idle(2, 1'b0);
    check("f55.rd_clears_full", 32'(rx_full), 32'(0));

    // Back-to-back frames, no read between them -> overrun.
    p0 = pulses;
    send_frame(8'hA3, 1'b1, -1);
    send_frame(8'h0F, 1'b1, -1);
    idle(2 * C, 1'b0);
    check_outs("b2b", 8'h0F, 1'b1, 1'b0, 1'b1);
    check("b2b.pulses", 32'(pulses - p0), 32'(2));
    pulse_rd();
    idle(2, 1'b0);
    check_outs("b2b_rd", 8'h0F, 1'b0, 1'b0, 1'b0);

    // Framing error while holding an unread byte.
    send_frame(8'h11, 1'b1, -1);
    idle(2 * C, 1'b0);
    p0 = pulses;
    send_frame(8'hFF, 1'b0, -1);
    idle(2 * C, 1'b0);
    check_outs("ferr", 8'h11, 1'b1, 1'b1, 1'b0);
    check("ferr.pulses", 32'(pulses - p0), 32'(0));
    pulse_rd();
    idle(2, 1'b0);
    check_outs("ferr_rd", 8'h11, 1'b0, 1'b0, 1'b0);

    // Short low glitch on an idle line.
    p0 = pulses;
    for (int i = 0; i < 4; i++) begin
      rx = 1'b0;
      @(negedge clk);
    end
    idle(3 * C, 1'b0);
    check_outs("glitch", 8'h11, 1'b0, 1'b0, 1'b0);
    check("glitch.pulses", 32'(pulses - p0), 32'(0));

    // Reset in the middle of data bit 3 of 0x3C, then a clean 0xC3.
    send_frame(8'h77, 1'b1, -1);
    idle(2 * C, 1'b0);
    bits = {1'b1, 8'h3C, 1'b0};
    e.t  = cyc + LAT; e.ok = 1'b1; e.b = 8'h3C;
    q.push_back(e);
    for (int i = 0; i < 4 * C + C / 2; i++) begin
      if (i > 0) @(negedge clk);
      k  = i / C;
      rx = bits[k[3:0]];
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_outs("midreset", 8'h00, 1'b0, 1'b0, 1'b0);
    rx = 1'b1;
    reset = 1'b0;
    idle(3 * C, 1'b0);
    check_outs("postreset", 8'h00, 1'b0, 1'b0, 1'b0);
    send_frame(8'hC3, 1'b1, -1);
    idle(2 * C, 1'b0);
    check_outs("fC3", 8'hC3, 1'b1, 1'b0, 1'b0);

    // rd sampled on the very edge frame 0x81 completes: load wins, no overrun.
    send_frame(8'h81, 1'b1, LAT - 1);
    idle(2 * C, 1'b0);
    check_outs("rd_same", 8'h81, 1'b1, 1'b0, 1'b0);

    // Break: line held low for several frame times, then released.
    pulse_rd();
    p0 = pulses;
    send_frame(8'h00, 1'b0, -1);
    for (int i = 0; i < 30 * C; i++) begin
      rx = 1'b0;
      @(negedge clk);
    end
    idle(2 * C, 1'b0);
    check_outs("break", 8'h81, 1'b0, 1'b1, 1'b0);
    check("break.pulses", 32'(pulses - p0), 32'(0));
    send_frame(8'h5A, 1'b1, -1);
    idle(2 * C, 1'b0);
    check_outs("after_break", 8'h5A, 1'b1, 1'b1, 1'b0);
    pulse_rd();
    idle(2, 1'b0);
    check_outs("after_break_rd", 8'h5A, 1'b0, 1'b0, 1'b0);

    // Randomized frames, gaps and reads, checked cycle by cycle by the model.
    prev_bad = 1'b0;
    for (int n = 0; n < 40; n++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 7) != 0);
      if (prev_bad)                     gap = C + int'($urandom_range(0, C));
      else if ($urandom_range(0, 1) == 0) gap = 0;
      else                              gap = int'($urandom_range(1, 2 * C));
      idle(gap, 1'b1);
      rd_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10 * C - 1)) : -1;
      send_frame(b, stop, rd_at);
      prev_bad = !stop;
    end
    idle(3 * C, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_con.md
UART_RX_CON -- requirements
Module: uart_rx_con

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clock cycles per serial bit (50 MHz / 115200 baud); legal range 8..65535.
REQ-002 Port clk  input  1  system clock, all logic on rising edge.
REQ-003 Port reset  input  1  synchronous, active-high reset; one clock; reset is synchronous and active-high.
REQ-004 Port rx  input  1  asynchronous serial line, idle high, 8N1 LSB-first framing.
REQ-005 Port rd  input  1  consumer read strobe; clears rx_full on the cycle it is sampled high.
REQ-006 Port data_out  output  8  last received byte (holding register).
REQ-007 Port rx_full  output  1  holding register contains an unread byte.
REQ-008 Port rx_done  output  1  one-cycle pulse when a frame completes with valid stop bit.
REQ-009 Port frame_err  output  1  sticky; stop bit sampled low.
REQ-010 Port overrun  output  1  sticky; new byte arrived while rx_full was high.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer before any use; all timing below counts from the synchronized signal.
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP; a 16-bit cycle counter and 3-bit bit index SHALL drive transitions.
REQ-013 IDLE: on synchronized rx = 0, go to START with counter cleared.
REQ-014 START: at counter = CLKS_PER_BIT/2 - 1 (integer division), resample rx; if 0 go to DATA with counter cleared, else (glitch) return to IDLE with no flags changed.
REQ-015 DATA: every CLKS_PER_BIT cycles sample rx into shift register bit [index], LSB first; after index 7 sampled go to STOP.
REQ-016 STOP: after CLKS_PER_BIT cycles sample rx; 1 = valid frame, 0 = framing error; return to IDLE next cycle.
REQ-017 Valid frame: data_out SHALL load the shifted byte, rx_full set, rx_done pulse high exactly one cycle, same edge.
REQ-018 Valid frame while rx_full = 1 and rd not high that cycle: data_out overwritten, overrun set, rx_done still pulses.
REQ-019 Framing error: frame_err set, data_out and rx_full unchanged, no rx_done pulse.
REQ-020 rd high while rx_full = 0 SHALL have no effect; rd and frame completion in the same cycle: load wins, rx_full ends at 1, no overrun.
REQ-021 rd high SHALL also clear frame_err and overrun (read-to-clear), except a flag being set the same cycle stays set.
REQ-022 Latency: rx_done SHALL assert 2 (sync) + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles after the rx falling edge, ±1.
REQ-023 Receiver SHALL accept back-to-back frames (stop bit immediately followed by next start bit) without loss.
REQ-024 rx held low continuously (break) SHALL produce data 0x00 with frame_err, then remain in IDLE until rx returns high.

Reset
REQ-025 reset high SHALL force state IDLE, counters 0, shift register 0, data_out = 0x00, rx_full = 0, rx_done = 0, frame_err = 0, overrun = 0, synchronizer flops = 1.
REQ-026 reset asserted mid-frame SHALL abort the frame with no outputs changed other than to reset values; reception restarts only on a new falling edge after reset deasserts.

Verification (CLKS_PER_BIT = 16)
REQ-027 Send 0x55 valid frame -> rx_done one-cycle pulse, data_out = 0x55, rx_full = 1, frame_err = 0.
REQ-028 Send 0xA3 then 0x0F back-to-back with no rd -> data_out = 0x0F, overrun = 1, two rx_done pulses; rd -> rx_full = 0, overrun = 0.
REQ-029 Send 0xFF with stop bit low -> frame_err = 1, rx_done never pulses, rx_full unchanged.
REQ-030 Low glitch of 4 cycles on idle rx -> FSM returns to IDLE, no flags, data_out unchanged.
REQ-031 Assert reset during bit 3 of frame 0x3C -> all outputs reset values; following frame 0xC3 received correctly.
REQ-032 rd asserted on the same cycle as frame 0x81 completes with rx_full = 1 -> rx_full = 1, overrun = 0, data_out = 0x81.
